lcd_bus_scheduler: RTL and testbench

Shared-bus scheduler for the Spartan-3AN starter-kit character LCD. Two requesters, for example an init/config sequencer and a text writer, submit single LCD write transactions (RS, 8-bit data, extra execution wait). The block arbitrates round-robin and runs the full LCD write cycle: setup, E pulse, hold and execution wait. It drives the board LCD pins and reports completion to the granted requester. It sits between the LCD pins and all higher-level display logic.

---
 rtl/lcd_bus_scheduler.sv | 147 ++++++++++++++
 tb/tb_lcd_bus_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_scheduler.sv
// Round-robin scheduler for two character-LCD write requesters; runs the full
// write cycle (setup, E pulse, hold, execution wait) on the board LCD pins.
module lcd_bus_scheduler #(
    parameter int E_SETUP  = 2,
    parameter int E_HIGH   = 12,
    parameter int EXEC_MIN = 2000,
    parameter int CNT_W    = 20
) (
    input  logic             CLK_50MHZ,
    input  logic             RST_N,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic             RS0,
    input  logic             RS1,
    input  logic [7:0]       DB0,
    input  logic [7:0]       DB1,
    input  logic [CNT_W-1:0] WAIT0,
    input  logic [CNT_W-1:0] WAIT1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             DONE0,
    output logic             DONE1,
    output logic             BUSY,
    output logic [7:0]       LCD_DB,
    output logic             LCD_E,
    output logic             LCD_RS,
    output logic             LCD_RW
);
    localparam int CW = CNT_W + 1;
    localparam logic [CW-1:0] SETUP_LOAD = CW'(E_SETUP - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(E_HIGH - 1);
    localparam logic [CW-1:0] EXEC_BASE  = CW'(EXEC_MIN - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             last_q, last_d;
    logic [7:0]       lcd_db_q, lcd_db_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             winner;
    logic             cnt_zero;

    // On a tie the port that was not served last wins; last_q also names the current owner.
    assign winner   = (REQ0 && REQ1) ? ~last_q : REQ1;
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        last_d   = last_q;
        lcd_db_d = lcd_db_q;
        lcd_rs_d = lcd_rs_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ0 || REQ1) begin
                    lcd_rs_d = winner ? RS1 : RS0;
                    lcd_db_d = winner ? DB1 : DB0;
                    wait_d   = winner ? WAIT1 : WAIT0;
                    last_d   = winner;
                    gnt0_d   = ~winner;
                    gnt1_d   = winner;
                    cnt_d    = SETUP_LOAD;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    cnt_d   = PULSE_LOAD;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                // One spare counter bit keeps EXEC_MIN plus the widest extra wait from wrapping.
                cnt_d   = EXEC_BASE + {1'b0, wait_q};
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wait_q   <= '0;
            last_q   <= 1'b1;
            lcd_db_q <= 8'h00;
            lcd_rs_q <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            last_q   <= last_d;
            lcd_db_q <= lcd_db_d;
            lcd_rs_q <= lcd_rs_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
        end
    end

    // Decoded from the state flop so E drops the instant reset is asserted.
    assign LCD_E  = (state_q == ST_PULSE);
    assign BUSY   = (state_q != ST_IDLE);
    assign DONE0  = (state_q == ST_EXEC) && cnt_zero && !last_q;
    assign DONE1  = (state_q == ST_EXEC) && cnt_zero && last_q;
    assign GNT0   = gnt0_q;
    assign GNT1   = gnt1_q;
    assign LCD_DB = lcd_db_q;
    assign LCD_RS = lcd_rs_q;
    assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench for lcd_bus_scheduler: per-cycle time-window reference model,
// a vector table of single transactions, hand-written corner sequences and random traffic.
module tb_lcd_bus_scheduler;
    localparam int E_SETUP  = 2;
    localparam int E_HIGH   = 12;
    localparam int EXEC_MIN = 20;
    localparam int CNT_W    = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0  = 1'b0;
    logic             req1  = 1'b0;
    logic             rs0   = 1'b0;
    logic             rs1   = 1'b0;
    logic [7:0]       db0   = 8'h00;
    logic [7:0]       db1   = 8'h00;
    logic [CNT_W-1:0] wait0 = '0;
    logic [CNT_W-1:0] wait1 = '0;
    logic             gnt0, gnt1, done0, done1, busy, lcd_e, lcd_rs, lcd_rw;
    logic [7:0]       lcd_db;

    lcd_bus_scheduler #(
        .E_SETUP(E_SETUP), .E_HIGH(E_HIGH), .EXEC_MIN(EXEC_MIN), .CNT_W(CNT_W)
    ) dut (
        .CLK_50MHZ(clk), .RST_N(rst_n),
        .REQ0(req0), .REQ1(req1), .RS0(rs0), .RS1(rs1),
        .DB0(db0), .DB1(db1), .WAIT0(wait0), .WAIT1(wait1),
        .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1), .BUSY(busy),
        .LCD_DB(lcd_db), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit               r0, r1, s0, s1;
        logic [7:0]       d0, d1;
        logic [CNT_W-1:0] w0, w1;
        bit               exp_port;
        logic [7:0]       exp_db;
        bit               exp_rs;
        int               exp_len;
    } vec_t;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // Reference model: one transaction is a window of cycle numbers fixed at grant time.
    bit         m_active = 1'b0;
    bit         m_last   = 1'b1;
    bit         m_port   = 1'b0;
    int         m_g      = 0;
    int         m_done   = 0;
    bit         m_rs     = 1'b0;
    logic [7:0] m_db     = 8'h00;

    int n_gnt = 0;
    int last_gnt_cyc = 0;
    bit last_gnt_port = 1'b0;
    int n_done = 0;
    int last_done_cyc = 0;
    bit last_done_port = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_last   = 1'b1;
        m_rs     = 1'b0;
        m_db     = 8'h00;
    endtask

    task automatic model_edge();
        int w;
        if (rst_n && (!m_active || cyc > m_done) && (req0 || req1)) begin
            m_port   = (req0 && req1) ? ~m_last : req1;
            m_last   = m_port;
            m_active = 1'b1;
            m_rs     = m_port ? rs1 : rs0;
            m_db     = m_port ? db1 : db0;
            w        = m_port ? int'(wait1) : int'(wait0);
            m_g      = cyc + 1;
            m_done   = m_g + E_SETUP + E_HIGH + EXEC_MIN + w;
        end
        cyc++;
    endtask

    function automatic logic [15:0] model_pins();
        bit in_txn, e;
        in_txn = m_active && cyc >= m_g && cyc <= m_done;
        e = in_txn && cyc >= m_g + E_SETUP && cyc < m_g + E_SETUP + E_HIGH;
        return {in_txn && cyc == m_g && !m_port, in_txn && cyc == m_g && m_port,
                in_txn && cyc == m_done && !m_port, in_txn && cyc == m_done && m_port,
                in_txn, e, m_rs, 1'b0, m_db};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check($sformatf("cyc%0d pins{gnt0,gnt1,done0,done1,busy,e,rs,rw,db}", cyc),
              {gnt0, gnt1, done0, done1, busy, lcd_e, lcd_rs, lcd_rw, lcd_db}, model_pins());
        if (gnt0 || gnt1) begin n_gnt++; last_gnt_cyc = cyc; last_gnt_port = gnt1; end
        if (done0 || done1) begin n_done++; last_done_cyc = cyc; last_done_port = done1; end
    endtask

    task automatic wait_gnt(input int limit, input string tag);
        int start;
        bit found;
        start = n_gnt;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            step();
            if (n_gnt != start) found = 1'b1;
        end
        check({tag, " grant seen"}, found, 1);
    endtask

    task automatic wait_done(input int limit, input string tag);
        int start;
        bit found;
        start = n_done;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            step();
            if (n_done != start) found = 1'b1;
        end
        check({tag, " done seen"}, found, 1);
    endtask

    task automatic apply_stimulus(input vec_t v);
        req0 = v.r0; req1 = v.r1; rs0 = v.s0; rs1 = v.s1;
        db0 = v.d0; db1 = v.d1; wait0 = v.w0; wait1 = v.w1;
    endtask

    // Runs one vector; data inputs are scrambled during the transaction to prove the pins hold.
    task automatic check_output(input vec_t v, input string tag);
        int g, first_e, e_cnt, moves, start;
        bit found;
        first_e = -1; e_cnt = 0; moves = 0; found = 1'b0;
        wait_gnt(8, tag);
        g = last_gnt_cyc;
        check({tag, " granted port"}, last_gnt_port, v.exp_port);
        check({tag, " LCD_DB at grant"}, lcd_db, v.exp_db);
        check({tag, " LCD_RS at grant"}, lcd_rs, v.exp_rs);
        req0 = 1'b0; req1 = 1'b0;
        start = n_done;
        for (int i = 0; i < 600 && !found; i++) begin
            rs0 = 1'($urandom); rs1 = 1'($urandom);
            db0 = 8'($urandom); db1 = 8'($urandom);
            step();
            if (lcd_e) begin
                if (first_e < 0) first_e = cyc;
                e_cnt++;
            end
            if (lcd_db !== v.exp_db || lcd_rs !== v.exp_rs || lcd_rw !== 1'b0) moves++;
            if (n_done != start) found = 1'b1;
        end
        check({tag, " done seen"}, found, 1);
        check({tag, " done port"}, last_done_port, v.exp_port);
        check({tag, " grant-to-done span"}, last_done_cyc - g + 1, v.exp_len);
        check({tag, " E start offset"}, first_e - g, E_SETUP);
        check({tag, " E high cycles"}, e_cnt, E_HIGH);
        check({tag, " pin changes during txn"}, moves, 0);
    endtask

    vec_t tbl[6];

    initial begin
        // Base transaction is 2 + 12 + 1 + 20 = 35 cycles from grant to done inclusive.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h38, 8'h00, 8'd0,   8'd0,  1'b0, 8'h38, 1'b0, 35};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h44, 8'd0,   8'd80, 1'b1, 8'h44, 1'b1, 115};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hC5, 8'h11, 8'd255, 8'd9,  1'b0, 8'hC5, 1'b1, 290};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hAA, 8'h55, 8'd9,   8'd3,  1'b1, 8'h55, 1'b0, 38};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h99, 8'd7,   8'd1,  1'b0, 8'h12, 1'b1, 42};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 8'h01, 8'd4,   8'd0,  1'b1, 8'h01, 1'b0, 35};

        #1;
        check("reset LCD_E", lcd_e, 0);
        check("reset BUSY", busy, 0);
        check("reset LCD_DB", lcd_db, 8'h00);
        check("reset GNT/DONE", {gnt0, gnt1, done0, done1}, 4'b0000);
        check("reset LCD_RW", lcd_rw, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        $display("[TB] tie after reset, held REQ1, re-raised REQ0");
        req0 = 1'b1; req1 = 1'b1; rs0 = 1'b0; db0 = 8'h38; wait0 = '0;
        rs1 = 1'b1; db1 = 8'h44; wait1 = 8'd5;
        wait_gnt(8, "tie");
        check("tie first winner", last_gnt_port, 0);
        req0 = 1'b0;
        wait_done(200, "tie port0");
        check("tie port0 span", last_done_cyc - last_gnt_cyc + 1, 35);
        wait_gnt(8, "held REQ1");
        check("held REQ1 port", last_gnt_port, 1);
        check("held REQ1 grant two cycles after done", last_gnt_cyc - last_done_cyc, 2);
        req1 = 1'b0; req0 = 1'b1; db0 = 8'h77;
        wait_gnt(200, "re-raised REQ0");
        check("re-raised REQ0 port", last_gnt_port, 0);
        check("re-raised REQ0 waited for DONE1", last_done_port, 1);
        check("re-raised REQ0 grant after DONE1", last_gnt_cyc - last_done_cyc, 2);
        req0 = 1'b0;
        wait_done(200, "re-raised REQ0");

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(tbl[i]);
            check_output(tbl[i], $sformatf("vec%0d", i));
        end

        $display("[TB] reset during E pulse");
        req1 = 1'b1; rs1 = 1'b1; db1 = 8'hE7; wait1 = '0;
        wait_gnt(8, "abort");
        req1 = 1'b0;
        for (int i = 0; i < 20 && !lcd_e; i++) step();
        check("abort reached PULSE", lcd_e, 1);
        step();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check("abort LCD_E low at once", lcd_e, 0);
        check("abort BUSY low at once", busy, 0);
        check("abort no DONE", {done0, done1}, 2'b00);
        check("abort LCD_DB cleared", lcd_db, 8'h00);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        req1 = 1'b1; rs1 = 1'b1; db1 = 8'h3C; wait1 = 8'd2;
        wait_gnt(8, "post-abort");
        check("post-abort port", last_gnt_port, 1);
        check("post-abort LCD_DB", lcd_db, 8'h3C);
        req1 = 1'b0;
        wait_done(200, "post-abort");
        check("post-abort span", last_done_cyc - last_gnt_cyc + 1, 37);

        $display("[TB] random traffic");
        begin
            int g0;
            g0 = n_gnt;
            for (int i = 0; i < 3000; i++) begin
                if (req0 && gnt0) req0 = 1'b0;
                else if (!req0 && $urandom_range(0, 7) == 0) begin
                    req0 = 1'b1; rs0 = 1'($urandom); db0 = 8'($urandom);
                    wait0 = CNT_W'($urandom_range(0, 15));
                end else if (req0 && $urandom_range(0, 31) == 0) req0 = 1'b0;
                if (req1 && gnt1) req1 = 1'b0;
                else if (!req1 && $urandom_range(0, 7) == 0) begin
                    req1 = 1'b1; rs1 = 1'($urandom); db1 = 8'($urandom);
                    wait1 = CNT_W'($urandom_range(0, 15));
                end else if (req1 && $urandom_range(0, 31) == 0) req1 = 1'b0;
                step();
            end
            req0 = 1'b0; req1 = 1'b0;
            for (int i = 0; i < 100 && busy; i++) step();
            check("random drained", busy, 0);
            check("random produced traffic", (n_gnt - g0) > 20, 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
